// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg
// Shared definitions for the pipelined ALU: operation codes, FSM state
// encoding and a small helper that identifies the multi-cycle shift ops.
// No ports (package only).
// Optional feature macro used by importers: ALU_PIPE_FLAGS_EN.

package alu_pipe_pkg;

  localparam int OP_W = 4;

  // Operation codes presented on the op port. Codes 4'hB..4'hF are
  // reserved and always produce a zero result.
  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NAND = 4'h5,
    OP_NOR  = 4'h6,
    OP_SHL1 = 4'h7,
    OP_SHLV = 4'h8,
    OP_SHRV = 4'h9,
    OP_SRAV = 4'hA
  } op_e;

  // Sequencer states: waiting for work, stepping a variable shift,
  // and presenting a finished result.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // True for the three shifts whose amount comes from operand b and
  // which are therefore stepped one bit per cycle.
  function automatic logic is_var_shift(input logic [OP_W-1:0] op);
    return (op == OP_SHLV) || (op == OP_SHRV) || (op == OP_SRAV);
  endfunction

endpackage

// File: rtl/alu_pipe_comb.sv
// alu_pipe_comb
// Purely combinational single-cycle ALU slice. Variable shifts pass operand
// a through unchanged: that is the correct answer for a zero shift amount,
// and any non-zero amount is stepped by the sequencer in alu_pipe.
// Ports:
//   i_a, i_b    operands (WIDTH bits)
//   i_op        operation code (see alu_pipe_pkg::op_e)
//   o_result    result (WIDTH bits)
//   o_carry     carry / not-borrow / shifted-out bit  (ALU_PIPE_FLAGS_EN only)
//   o_overflow  signed overflow for ADD/SUB           (ALU_PIPE_FLAGS_EN only)
// Macro: ALU_PIPE_FLAGS_EN adds the carry and overflow outputs.

module alu_pipe_comb
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [OP_W-1:0]  i_op,
  output logic [WIDTH-1:0] o_result
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output logic             o_carry,
  output logic             o_overflow
`endif
);

  // Result mux. Arithmetic wraps naturally at WIDTH bits.
  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NAND: o_result = ~(i_a & i_b);
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_SHL1: o_result = {i_a[WIDTH-2:0], 1'b0};
      OP_SHLV, OP_SHRV, OP_SRAV: o_result = i_a;
      default: o_result = '0;
    endcase
  end

`ifdef ALU_PIPE_FLAGS_EN
  // Flags derived from the operand and result sign bits. The ADD carry-out
  // follows from the MSB full-adder: generate, or propagate with a carry-in
  // (a carry-in shows up as a cleared result MSB when exactly one operand
  // MSB is set). SUB carry means "no borrow", i.e. a >= b unsigned.
  always_comb begin
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_carry    = (i_a[WIDTH-1] & i_b[WIDTH-1]) |
                     ((i_a[WIDTH-1] | i_b[WIDTH-1]) & ~o_result[WIDTH-1]);
        o_overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                     (o_result[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        o_carry    = (i_a >= i_b);
        o_overflow = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                     (o_result[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SHL1: o_carry = i_a[WIDTH-1];
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe
// Handshaked ALU. Single-cycle ops finish one cycle after acceptance;
// variable shifts with a non-zero amount N are stepped one bit per cycle
// and finish N+1 cycles after acceptance. The result is held until the
// consumer takes it.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operation presented       in_ready   can accept (IDLE only)
//   a, b       operands (WIDTH bits)     op         operation code (4 bits)
//   out_valid  result valid              out_ready  consumer takes result
//   result     registered result         zero       registered result == 0
//   carry, overflow, negative            registered flags (ALU_PIPE_FLAGS_EN)
// Macro: ALU_PIPE_FLAGS_EN adds the carry/overflow/negative outputs.

module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output logic             carry,
  output logic             overflow,
  output logic             negative
`endif
);

  localparam int SHW = $clog2(WIDTH);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_comb_result;
  logic [WIDTH-1:0] w_shift_next;
  logic [OP_W-1:0]  r_op;
  logic [SHW-1:0]   r_cnt;
  logic [SHW-1:0]   w_amt;
  logic             r_zero;
  logic             w_accept;
  logic             w_seq_start;
  logic             w_last_step;

`ifdef ALU_PIPE_FLAGS_EN
  logic r_carry;
  logic r_overflow;
  logic r_negative;
  logic w_comb_carry;
  logic w_comb_overflow;
  logic w_shift_out;
`endif

  alu_pipe_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .i_a        (a),
    .i_b        (b),
    .i_op       (op),
    .o_result   (w_comb_result)
`ifdef ALU_PIPE_FLAGS_EN
    ,
    .o_carry    (w_comb_carry),
    .o_overflow (w_comb_overflow)
`endif
  );

  // Shift amount is the low SHW bits of b; a zero amount takes the
  // single-cycle path through the combinational slice.
  assign w_amt       = b[SHW-1:0];
  assign w_accept    = in_valid && (r_state == S_IDLE);
  assign w_seq_start = is_var_shift(op) && (w_amt != '0);
  assign w_last_step = (r_cnt == SHW'(1));

  // One-bit step of the shift in progress, selected by the captured op.
  always_comb begin
    w_shift_next = r_result;
    case (r_op)
      OP_SHLV: w_shift_next = {r_result[WIDTH-2:0], 1'b0};
      OP_SHRV: w_shift_next = {1'b0, r_result[WIDTH-1:1]};
      OP_SRAV: w_shift_next = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
      default: ;
    endcase
  end

`ifdef ALU_PIPE_FLAGS_EN
  // The bit falling off the end on this step; the final step's value is
  // what remains in the carry flag.
  assign w_shift_out = (r_op == OP_SHLV) ? r_result[WIDTH-1] : r_result[0];
`endif

  // State register; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. In SHIFT the down-counter holds the number of steps
  // still to do, so the step taken while it reads 1 is the last one.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = w_seq_start ? S_SHIFT : S_DONE;
      S_SHIFT: if (w_last_step) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state alone.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath. The result register doubles as the shift register while a
  // variable shift is being stepped. zero is only ever set on entry to DONE
  // and cleared when the result is consumed, so it is meaningful exactly
  // while out_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_cnt      <= '0;
      r_op       <= '0;
`ifdef ALU_PIPE_FLAGS_EN
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_negative <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op <= op;
            if (w_seq_start) begin
              r_result   <= a;
              r_cnt      <= w_amt;
              r_zero     <= 1'b0;
`ifdef ALU_PIPE_FLAGS_EN
              r_carry    <= 1'b0;
              r_overflow <= 1'b0;
              r_negative <= 1'b0;
`endif
            end else begin
              r_result   <= w_comb_result;
              r_zero     <= (w_comb_result == '0);
`ifdef ALU_PIPE_FLAGS_EN
              r_carry    <= w_comb_carry;
              r_overflow <= w_comb_overflow;
              r_negative <= w_comb_result[WIDTH-1];
`endif
            end
          end
        end
        S_SHIFT: begin
          r_result <= w_shift_next;
          r_cnt    <= r_cnt - SHW'(1);
          if (w_last_step) begin
            r_zero <= (w_shift_next == '0);
          end
`ifdef ALU_PIPE_FLAGS_EN
          r_carry    <= w_shift_out;
          r_overflow <= 1'b0;
          r_negative <= w_shift_next[WIDTH-1];
`endif
        end
        S_DONE: begin
          if (out_ready) begin
            r_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign zero   = r_zero;

`ifdef ALU_PIPE_FLAGS_EN
  assign carry    = r_carry;
  assign overflow = r_overflow;
  assign negative = r_negative;
`endif

endmodule
